// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width limits, tap masks and XNOR forward/inverse step helpers.
// Used by the counter RTL and by its reference checks.
package lfsr_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  typedef logic [MAX_WIDTH-1:0] lfsr_word_t;

  // Maximal-length tap masks, bit t set for tap t (0-indexed).
  function automatic lfsr_word_t TAPS(input int width);
    case (width)
      3:       TAPS = 16'h0006;
      4:       TAPS = 16'h000C;
      5:       TAPS = 16'h0014;
      6:       TAPS = 16'h0030;
      7:       TAPS = 16'h0060;
      8:       TAPS = 16'h00B8;
      9:       TAPS = 16'h0110;
      10:      TAPS = 16'h0240;
      11:      TAPS = 16'h0500;
      12:      TAPS = 16'h0829;
      13:      TAPS = 16'h100D;
      14:      TAPS = 16'h2015;
      15:      TAPS = 16'h6000;
      16:      TAPS = 16'hD008;
      default: TAPS = '0;
    endcase
  endfunction

  function automatic lfsr_word_t width_mask(input int width);
    width_mask = lfsr_word_t'((32'd1 << width) - 32'd1);
  endfunction

  function automatic lfsr_word_t lfsr_fwd(input lfsr_word_t s, input int width);
    logic fb;
    fb = ~^(s & TAPS(width));
    lfsr_fwd = ((s << 1) | lfsr_word_t'(fb)) & width_mask(width);
  endfunction

  // Recovers the bit shifted out by lfsr_fwd; taps below the MSB now sit one place higher.
  function automatic lfsr_word_t lfsr_inv(input lfsr_word_t s, input int width);
    logic r;
    logic top;
    r   = ^((s >> 1) & TAPS(width) & (width_mask(width) >> 1));
    top = ~(s[0] ^ r);
    lfsr_inv = ((s >> 1) | (lfsr_word_t'(top) << (width - 1))) & width_mask(width);
  endfunction

  function automatic lfsr_word_t LFSR_IDX_OF(input lfsr_word_t v, input int width);
    lfsr_word_t s;
    logic       found;
    int         lim;
    s           = '0;
    found       = 1'b0;
    lim         = (1 << width) - 1;
    LFSR_IDX_OF = '0;
    for (int i = 0; i < lim && !found; i++) begin
      if (s == v) begin
        LFSR_IDX_OF = lfsr_word_t'(i);
        found       = 1'b1;
      end
      s = lfsr_fwd(s, width);
    end
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR step: forward or inverse successor of i_state plus the wrap flag
// (LAST->ZERO going up, ZERO->LAST going down).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] LAST = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_inv;

  assign w_fwd  = WIDTH'(lfsr_fwd(lfsr_word_t'(i_state), WIDTH));
  assign w_inv  = WIDTH'(lfsr_inv(lfsr_word_t'(i_state), WIDTH));
  assign o_next = i_up ? w_fwd : w_inv;
  assign o_wrap = i_up ? (i_state == LAST) : (i_state == ZERO);

endmodule

// File: rtl/lfsr_updown_gen.sv
// Up/down XNOR LFSR counter with guarded parallel load, wrap pulse and match compare.
// Optional binary index output enabled by defining LFSR_BINIDX_EN.
module lfsr_updown_gen
  import lfsr_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] match_value,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             match,
  output logic             load_err
`ifdef LFSR_BINIDX_EN
  ,
  output logic [WIDTH-1:0] idx,
  output logic             idx_valid
`endif
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_updown_gen: WIDTH %0d outside legal range", WIDTH);
  end
  if (RESET_VAL == {WIDTH{1'b1}}) begin : g_bad_reset
    $error("lfsr_updown_gen: RESET_VAL all-ones is the XNOR lock-up state");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             r_load_err;
  logic [WIDTH-1:0] w_step_next;
  logic             w_step_wrap;
  logic             w_load_bad;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .i_state (r_count),
    .i_up    (up_down),
    .o_next  (w_step_next),
    .o_wrap  (w_step_wrap)
  );

  assign w_load_bad = &load_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= RESET_VAL;
      r_overflow <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_bad) r_load_err <= 1'b1;
        else            r_count    <= load_value;
      end else if (enable) begin
        r_count    <= w_step_next;
        r_overflow <= w_step_wrap;
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign load_err = r_load_err;
  assign match    = (r_count == match_value);

`ifdef LFSR_BINIDX_EN
  localparam logic [WIDTH-1:0] IDX_LAST  = WIDTH'((32'd1 << WIDTH) - 32'd2);
  localparam logic [WIDTH-1:0] IDX_RESET =
    (RESET_VAL == '0) ? '0 : WIDTH'(LFSR_IDX_OF(lfsr_word_t'(RESET_VAL), WIDTH));

  logic [WIDTH-1:0] r_idx;
  logic             r_idx_valid;

  // A rejected load leaves count untouched, so only an accepted load loses the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= IDX_RESET;
      r_idx_valid <= 1'b1;
    end else if (load) begin
      if (!w_load_bad) r_idx_valid <= 1'b0;
    end else if (enable) begin
      if (up_down) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      else         r_idx <= (r_idx == '0) ? IDX_LAST : r_idx - 1'b1;
    end
  end

  assign idx       = r_idx;
  assign idx_valid = r_idx_valid;
`endif

endmodule
